twos_to_sign_mag: RTL

TWOS_TO_SIGN_MAG -- requirements
Module: twos_to_sign_mag

---
 rtl/sm_conv_pkg.sv | 7 +
 rtl/serial_negate_bit.sv | 11 +
 rtl/twos_to_sign_mag.sv | 114 +++++++++++
 3 files changed

// File: rtl/sm_conv_pkg.sv
// Shared types and constants for the serial two's-complement to sign-magnitude converter.
package sm_conv_pkg;
   localparam int WIDTH_DEF = 8;
   localparam logic [WIDTH_DEF-1:0] MOST_NEG = 8'h80;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/serial_negate_bit.sv
// One bit step of serial two's-complement negation: bits pass until the first 1, then invert.
module serial_negate_bit (
   input  logic in_bit,
   input  logic neg,
   input  logic seen_one,
   output logic out_bit,
   output logic seen_one_next
);
   assign out_bit       = neg ? (in_bit ^ seen_one) : in_bit;
   assign seen_one_next = seen_one | in_bit;
endmodule

// File: rtl/twos_to_sign_mag.sv
// Bit-serial two's-complement to sign-magnitude converter with valid/ready handshake.
// Define SM_SAT_EN to saturate the most negative operand to -(2^(WIDTH-1)-1).
module twos_to_sign_mag
   import sm_conv_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             ovfl
);
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [WIDTH-2:0] res_q, res_d;
   logic             sign_q, sign_d;
   logic             seen_q, seen_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             ovfl_q, ovfl_d;

   logic             nbit, seen_nxt;
   logic [WIDTH-1:0] res_full;

   serial_negate_bit u_neg (
      .in_bit        (opnd_q[0]),
      .neg           (sign_q),
      .seen_one      (seen_q),
      .out_bit       (nbit),
      .seen_one_next (seen_nxt)
   );

   // Result as it stands once the current bit has been shifted in.
   assign res_full = {nbit, res_q};

   always_comb begin
      state_d = state_q;
      opnd_d  = opnd_q;
      res_d   = res_q;
      sign_d  = sign_q;
      seen_d  = seen_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      ovfl_d  = ovfl_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               opnd_d  = in_data;
               sign_d  = in_data[WIDTH-1];
               res_d   = '0;
               seen_d  = 1'b0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            opnd_d = opnd_q >> 1;
            res_d  = res_full[WIDTH-1:1];
            seen_d = seen_nxt;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               // Only the most negative operand negates back to itself.
               ovfl_d = (res_full == WIDTH'(MOST_NEG));
`ifdef SM_SAT_EN
               if (ovfl_d) dout_d = '1;
               else        dout_d = {sign_q, res_full[WIDTH-2:0]};
`else
               dout_d = {sign_q, res_full[WIDTH-2:0]};
`endif
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         opnd_q  <= '0;
         res_q   <= '0;
         sign_q  <= 1'b0;
         seen_q  <= 1'b0;
         cnt_q   <= '0;
         dout_q  <= '0;
         ovfl_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         opnd_q  <= opnd_d;
         res_q   <= res_d;
         sign_q  <= sign_d;
         seen_q  <= seen_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         ovfl_q  <= ovfl_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign d         = dout_q;
   assign ovfl      = ovfl_q;
endmodule
